if_fetch_stage: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the current PC value,

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/if_fetch_stage_if.sv | 34 +++
 rtl/if_skid_buf.sv | 52 +++++
 rtl/if_fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage.
//   XLEN          : datapath / address width
//   NOP_INSTR     : instruction presented to ID whenever IF/ID holds nothing valid
//   TIMEOUT       : cycles a fetch may wait for its response before it is faulted
//   CNT_W         : width of the response-timeout counter
//   fetch_state_e : fetch FSM encoding
//   fetch_entry_t : one IF/ID entry {pc, instr, fault}
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam int TIMEOUT = 255;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_FULL  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            fault;
   } fetch_entry_t;

   // Sequential PC of the following instruction, wrapping modulo 2^XLEN.
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//   req / addr   : fetch request and its address (fetch stage -> memory)
//   gnt          : memory accepted the request this cycle
//   rvalid/rdata : response for the single outstanding request
// Handshake: a request transfers in a cycle where req=1 and gnt=1. Until gnt
// the address may change. After a transfer exactly one response follows with
// rvalid=1 for one cycle, at the earliest one cycle after gnt; the response
// has no back-pressure, so the requester must be able to absorb it.
interface if_fetch_stage_if;
   import cpu_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr, fault} entry that could
// not enter IF/ID because ID was stalled.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : drop the held entry (highest priority after reset)
//   load_i       : capture entry_i
//   unload_i     : entry has been consumed
//   entry_i      : entry to capture
//   valid_o      : buffer holds an entry
//   entry_o      : held entry
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic         unload_i,
   input  fetch_entry_t entry_i,
   output logic         valid_o,
   output fetch_entry_t entry_o
);

   logic         valid_q, valid_d;
   fetch_entry_t entry_q, entry_d;

   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         entry_d = entry_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         entry_q <= '{pc: '0, instr: NOP_INSTR, fault: 1'b0};
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign valid_o = valid_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage between the PC register and ID. Issues one fetch at
// a time, loads the IF/ID register, and stalls the PC so it advances exactly
// once per instruction that enters IF/ID. A one-entry skid buffer absorbs a
// response that arrives while ID is stalled; a redirect flush discards
// everything fetched or still in flight.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   pc_i           : current PC
//   pc_stall_o     : 0 = PC loads its next value this edge
//   flush_i        : branch redirect
//   imem           : instruction-memory port (master side)
//   id_stall_i     : ID cannot take a new instruction
//   id_valid_o     : IF/ID holds a valid instruction
//   id_pc_o        : PC of the IF/ID instruction
//   id_pc_plus4_o  : id_pc_o + 4 (wrapping)
//   id_instr_o     : IF/ID instruction, NOP_INSTR when not valid
//   id_fault_o     : IF/ID entry is a fetch-timeout fault
//   state_o        : current fetch FSM state
module if_fetch_stage
   import cpu_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [XLEN-1:0]       pc_i,
   output logic                  pc_stall_o,
   input  logic                  flush_i,
   if_fetch_stage_if.master      imem,
   input  logic                  id_stall_i,
   output logic                  id_valid_o,
   output logic [XLEN-1:0]       id_pc_o,
   output logic [XLEN-1:0]       id_pc_plus4_o,
   output logic [XLEN-1:0]       id_instr_o,
   output logic                  id_fault_o,
   output fetch_state_e          state_o
);

   fetch_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            id_valid_q, id_valid_d;
   fetch_entry_t    id_q, id_d;

   logic            req;
   logic            ifid_load;
   fetch_entry_t    ifid_entry;
   logic            skid_load;
   logic            skid_unload;
   fetch_entry_t    skid_in;
   logic            skid_valid;
   fetch_entry_t    skid_out;

   logic            can_take;
   logic            timeout;
   fetch_entry_t    resp_entry;
   fetch_entry_t    fault_entry;

   // IF/ID can accept a new entry when it is empty or ID consumes it now.
   assign can_take    = !id_valid_q || !id_stall_i;
   assign timeout     = (cnt_q == CNT_W'(TIMEOUT));
   assign resp_entry  = '{pc: pend_pc_q, instr: imem.rdata, fault: 1'b0};
   assign fault_entry = '{pc: pend_pc_q, instr: NOP_INSTR, fault: 1'b1};

   if_skid_buf u_skid (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (flush_i),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .entry_i  (skid_in),
      .valid_o  (skid_valid),
      .entry_o  (skid_out)
   );

   // Fetch FSM: next state, counter and IF/ID / skid load strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_pc_d   = pend_pc_q;
      req         = 1'b0;
      ifid_load   = 1'b0;
      ifid_entry  = resp_entry;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_in     = resp_entry;

      unique case (state_q)
         S_REQ: begin
            req       = 1'b1;
            pend_pc_d = pc_i;
            if (imem.gnt) begin
               cnt_d   = '0;
               // A request granted under a flush fetches the stale PC; its
               // response must be thrown away.
               state_d = flush_i ? S_DRAIN : S_WAIT;
            end
         end

         S_WAIT: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = imem.rvalid ? S_REQ : S_DRAIN;
            end else if (imem.rvalid) begin
               if (can_take) begin
                  ifid_load = 1'b1;
                  state_d   = S_REQ;
               end else begin
                  skid_load = 1'b1;
                  state_d   = S_FULL;
               end
            end else if (timeout) begin
               // The missing response becomes a fault entry; the real one may
               // still arrive later and is drained.
               cnt_d = '0;
               if (can_take) begin
                  ifid_load  = 1'b1;
                  ifid_entry = fault_entry;
               end else begin
                  skid_load = 1'b1;
                  skid_in   = fault_entry;
               end
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_FULL: begin
            if (flush_i) begin
               state_d = S_REQ;
            end else if (!id_stall_i) begin
               ifid_load   = 1'b1;
               ifid_entry  = skid_out;
               skid_unload = 1'b1;
               state_d     = S_REQ;
            end
         end

         S_DRAIN: begin
            // A fault entry parked in the skid buffer may move on while the
            // stale response is still outstanding.
            if (!flush_i && skid_valid && !id_stall_i) begin
               ifid_load   = 1'b1;
               ifid_entry  = skid_out;
               skid_unload = 1'b1;
            end
            // A flush does not end the drain: the stale response is still
            // owed and is discarded whenever it arrives.
            if (imem.rvalid || timeout) begin
               cnt_d   = '0;
               state_d = (skid_valid && !skid_unload && !flush_i) ? S_FULL : S_REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // IF/ID register next value; flush wins even over an ID stall.
   always_comb begin
      id_valid_d = id_valid_q;
      id_d       = id_q;
      if (flush_i) begin
         id_valid_d = 1'b0;
      end else if (ifid_load) begin
         id_valid_d = 1'b1;
         id_d       = ifid_entry;
      end else if (!id_stall_i) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_REQ;
         cnt_q      <= '0;
         pend_pc_q  <= '0;
         id_valid_q <= 1'b0;
         id_q       <= '{pc: '0, instr: NOP_INSTR, fault: 1'b0};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_pc_q  <= pend_pc_d;
         id_valid_q <= id_valid_d;
         id_q       <= id_d;
      end
   end

   assign imem.req      = req && !rst_i;
   assign imem.addr     = pc_i;
   // The PC moves only when an instruction enters IF/ID or on a redirect.
   assign pc_stall_o    = rst_i ? 1'b1 : !(ifid_load || flush_i);

   assign id_valid_o    = id_valid_q;
   assign id_pc_o       = id_q.pc;
   assign id_pc_plus4_o = pc_plus4(id_q.pc);
   assign id_instr_o    = id_valid_q ? id_q.instr : NOP_INSTR;
   assign id_fault_o    = id_valid_q && id_q.fault;
   assign state_o       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  pc;
  logic         pc_stall;
  logic         flush;
  logic         id_stall;
  logic         id_valid;
  logic [31:0]  id_pc;
  logic [31:0]  id_pc_plus4;
  logic [31:0]  id_instr;
  logic         id_fault;
  fetch_state_e state;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_i          (pc),
    .pc_stall_o    (pc_stall),
    .flush_i       (flush),
    .imem          (imem_bus),
    .id_stall_i    (id_stall),
    .id_valid_o    (id_valid),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc_plus4),
    .id_instr_o    (id_instr),
    .id_fault_o    (id_fault),
    .state_o       (state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic new_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: an instruction that entered IF/ID at the last edge must be the
  // next one in the expected stream.
  task automatic sample_cycle();
    logic [31:0] e;
    if (new_pending) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: entry %h arrived with no expected instruction left", id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", id_instr, e);
      end
    end
    new_pending = !pc_stall && !flush && !rst;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] p, input logic g, input logic rv,
                       input logic [31:0] rd, input logic st, input logic fl);
    @(negedge clk);
    rst             = 1'b0;
    pc              = p;
    imem_bus.gnt    = g;
    imem_bus.rvalid = rv;
    imem_bus.rdata  = rd;
    id_stall        = st;
    flush           = fl;
    #1;
    sample_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]  pc;
    logic         gnt;
    logic         rv;
    logic [31:0]  rdata;
    logic         stall;
    logic         flush;
    fetch_state_e e_state;
    logic         e_req;
    logic         e_pcs;
    logic         e_valid;
    logic [31:0]  e_pc;
    logic [31:0]  e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] p, input logic g, input logic rv,
                              input logic [31:0] rd, input logic st, input logic fl,
                              input fetch_state_e es, input logic er, input logic eps,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei);
    vec_t r;
    r.pc = p; r.gnt = g; r.rv = rv; r.rdata = rd; r.stall = st; r.flush = fl;
    r.e_state = es; r.e_req = er; r.e_pcs = eps; r.e_valid = ev;
    r.e_pc = epc; r.e_instr = ev ? ei : NOP_INSTR;
    return r;
  endfunction

  localparam logic [31:0] A0 = 32'h00a0_0093, A1 = 32'h00a1_0113, A2 = 32'h00a2_0193;
  localparam logic [31:0] A3 = 32'h00a3_0213, B0 = 32'h00b0_0293, B1 = 32'h00b1_0313;
  localparam logic [31:0] B2 = 32'h00b2_0393, C0 = 32'h00c0_0413, C1 = 32'h00c1_0493;
  localparam logic [31:0] DEAD = 32'hdead_beef, BAD = 32'h0bad_0bad, E0 = 32'h00e0_0513;
  localparam logic [31:0] PCW = 32'hffff_fffc;

  initial begin
    int n;
    vec_t v;

    // pc gnt rv rdata stall flush | state req pc_stall valid id_pc instr
    vecs.push_back(mk(32'h000,1,0,0   ,0,0, S_REQ  ,1,1,0,0,0));
    vecs.push_back(mk(32'h000,0,1,A0  ,0,0, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h004,1,0,0   ,0,0, S_REQ  ,1,1,1,32'h000,A0));
    vecs.push_back(mk(32'h004,0,1,A1  ,0,0, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h008,1,0,0   ,0,0, S_REQ  ,1,1,1,32'h004,A1));
    vecs.push_back(mk(32'h008,0,1,A2  ,0,0, S_WAIT ,0,0,0,0,0));
    for (int i = 0; i < 5; i++)  // gnt held low five cycles, ID stalled
      vecs.push_back(mk(32'h00c,0,0,0 ,1,0, S_REQ  ,1,1,1,32'h008,A2));
    vecs.push_back(mk(32'h00c,1,0,0   ,1,0, S_REQ  ,1,1,1,32'h008,A2));
    vecs.push_back(mk(32'h00c,0,1,A3  ,1,0, S_WAIT ,0,1,1,32'h008,A2));
    vecs.push_back(mk(32'h00c,0,0,0   ,1,0, S_FULL ,0,1,1,32'h008,A2));
    vecs.push_back(mk(32'h00c,0,0,0   ,0,0, S_FULL ,0,0,1,32'h008,A2));
    vecs.push_back(mk(32'h010,1,0,0   ,0,0, S_REQ  ,1,1,1,32'h00c,A3));
    vecs.push_back(mk(32'h010,0,0,0   ,0,1, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h100,0,0,0   ,0,0, S_DRAIN,0,1,0,0,0));
    vecs.push_back(mk(32'h100,0,0,0   ,0,0, S_DRAIN,0,1,0,0,0));
    vecs.push_back(mk(32'h100,0,1,DEAD,0,0, S_DRAIN,0,1,0,0,0));
    vecs.push_back(mk(32'h100,1,0,0   ,0,0, S_REQ  ,1,1,0,0,0));
    vecs.push_back(mk(32'h100,0,1,B0  ,0,0, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h104,0,0,0   ,0,0, S_REQ  ,1,1,1,32'h100,B0));
    vecs.push_back(mk(32'h104,0,0,0   ,0,1, S_REQ  ,1,0,0,0,0));
    vecs.push_back(mk(32'h200,1,0,0   ,0,0, S_REQ  ,1,1,0,0,0));
    vecs.push_back(mk(32'h200,0,1,B1  ,0,1, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h300,1,0,0   ,0,0, S_REQ  ,1,1,0,0,0));
    vecs.push_back(mk(32'h300,0,1,B2  ,0,0, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h304,0,0,0   ,1,0, S_REQ  ,1,1,1,32'h300,B2));
    vecs.push_back(mk(32'h304,0,0,0   ,1,1, S_REQ  ,1,0,1,32'h300,B2));
    vecs.push_back(mk(PCW    ,1,0,0   ,0,0, S_REQ  ,1,1,0,0,0));
    vecs.push_back(mk(PCW    ,0,1,C0  ,0,0, S_WAIT ,0,0,0,0,0));
    vecs.push_back(mk(32'h000,0,0,0   ,1,0, S_REQ  ,1,1,1,PCW,C0));
    vecs.push_back(mk(32'h000,1,0,0   ,1,0, S_REQ  ,1,1,1,PCW,C0));
    vecs.push_back(mk(32'h000,0,1,C1  ,1,0, S_WAIT ,0,1,1,PCW,C0));
    vecs.push_back(mk(32'h000,0,0,0   ,1,0, S_FULL ,0,1,1,PCW,C0));

    // Instructions that must reach IF/ID, in order (B1, DEAD dropped; C1 killed by reset).
    exp_q = '{A0, A1, A2, A3, B0, B2, C0};

    // ---- reset ----
    rst = 1'b1; pc = '0; flush = 1'b0; id_stall = 1'b0;
    imem_bus.gnt = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    sample_cycle();
    chk("rst_req", 32'(imem_bus.req), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_state", 32'(state), 32'(S_REQ));
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, NOP_INSTR);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_fault", 32'(id_fault), 32'd0);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.pc, v.gnt, v.rv, v.rdata, v.stall, v.flush);
      chk($sformatf("row%0d_state", i), 32'(state), 32'(v.e_state));
      chk($sformatf("row%0d_req", i), 32'(imem_bus.req), 32'(v.e_req));
      if (v.e_req) chk($sformatf("row%0d_addr", i), imem_bus.addr, v.pc);
      chk($sformatf("row%0d_pc_stall", i), 32'(pc_stall), 32'(v.e_pcs));
      chk($sformatf("row%0d_valid", i), 32'(id_valid), 32'(v.e_valid));
      chk($sformatf("row%0d_instr", i), id_instr, v.e_instr);
      chk($sformatf("row%0d_fault", i), 32'(id_fault), 32'd0);
      if (v.e_valid) begin
        chk($sformatf("row%0d_id_pc", i), id_pc, v.e_pc);
        chk($sformatf("row%0d_plus4", i), id_pc_plus4, v.e_pc + 32'd4);
      end
    end
    chk("wrap_plus4", id_pc_plus4, 32'h0000_0000);

    // ---- reset while in S_FULL ----
    @(negedge clk);
    rst = 1'b1;
    #1;
    sample_cycle();
    chk("rst_full_req", 32'(imem_bus.req), 32'd0);
    chk("rst_full_pc_stall", 32'(pc_stall), 32'd1);
    @(negedge clk);
    #1;
    sample_cycle();
    chk("rst_full_state", 32'(state), 32'(S_REQ));
    chk("rst_full_valid", 32'(id_valid), 32'd0);
    chk("rst_full_instr", id_instr, NOP_INSTR);
    chk("rst_full_id_pc", id_pc, 32'd0);
    chk("rst_full_plus4", id_pc_plus4, 32'd4);
    chk("rst_full_fault", 32'(id_fault), 32'd0);

    // ---- response timeout, late response discarded ----
    exp_q.push_back(NOP_INSTR);
    exp_q.push_back(E0);
    drive(32'h500, 1, 0, 0, 0, 0);
    chk("to_req", 32'(imem_bus.req), 32'd1);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      drive(32'h500, 0, 0, 0, 0, 0);
      n = k;
      if (k == 128) chk("to_quiet_valid", 32'(id_valid), 32'd0);
      if (!pc_stall) break;
    end
    chk("to_cycles", 32'(n), 32'd256);
    drive(32'h504, 0, 0, 0, 0, 0);
    chk("to_state", 32'(state), 32'(S_DRAIN));
    chk("to_valid", 32'(id_valid), 32'd1);
    chk("to_fault", 32'(id_fault), 32'd1);
    chk("to_instr", id_instr, NOP_INSTR);
    chk("to_id_pc", id_pc, 32'h500);
    drive(32'h504, 0, 1, BAD, 0, 0);
    chk("late_pc_stall", 32'(pc_stall), 32'd1);
    chk("late_state", 32'(state), 32'(S_DRAIN));
    drive(32'h504, 1, 0, 0, 0, 0);
    chk("late_state2", 32'(state), 32'(S_REQ));
    chk("late_valid", 32'(id_valid), 32'd0);
    chk("late_fault", 32'(id_fault), 32'd0);
    drive(32'h504, 0, 1, E0, 0, 0);
    chk("post_pc_stall", 32'(pc_stall), 32'd0);
    drive(32'h508, 0, 0, 0, 0, 0);
    chk("post_valid", 32'(id_valid), 32'd1);
    chk("post_id_pc", id_pc, 32'h504);
    chk("post_instr", id_instr, E0);

    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
